// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The lock signal exists only when ARBITER_LOCK_EN is defined.
interface round_robin_arbiter_if #(
   parameter int N = 2
);
   logic [2**N-1:0] req;
   logic            gnt_ready;
   logic [N-1:0]    gnt_idx;
   logic            gnt_valid;
`ifdef ARBITER_LOCK_EN
   logic            lock;

   modport master (
      output req, gnt_ready, lock,
      input  gnt_idx, gnt_valid
   );

   modport slave (
      input  req, gnt_ready, lock,
      output gnt_idx, gnt_valid
   );
`else
   modport master (
      output req, gnt_ready,
      input  gnt_idx, gnt_valid
   );

   modport slave (
      input  req, gnt_ready,
      output gnt_idx, gnt_valid
   );
`endif
endinterface

// File: rtl/round_robin_arbiter.sv
// Sticky round-robin arbiter over 2**N requesters with a one-cycle bubble between grants.
// Optional grant retention via the lock input is compiled in with ARBITER_LOCK_EN.
module round_robin_arbiter #(
   parameter int N = 2
) (
   input logic                  clock,
   input logic                  reset,
   round_robin_arbiter_if.slave bus
);

   localparam int              NREQ     = 2**N;
   localparam logic [N-1:0]    PTR_STEP = N'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t         state_q;
   logic [N-1:0]   ptr_q;
   logic [N-1:0]   gnt_idx_q;
   logic           gnt_valid_q;

   logic [N-1:0]   scan_s;
   logic [N-1:0]   sel_idx_d;
   logic           sel_found_d;
   logic           release_d;

   // First set request at or after ptr_q, wrapping modulo 2**N
   always_comb begin
      sel_idx_d   = '0;
      sel_found_d = 1'b0;
      scan_s      = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_s = ptr_q + N'(k);
         if (!sel_found_d && bus.req[scan_s]) begin
            sel_found_d = 1'b1;
            sel_idx_d   = scan_s;
         end else begin
            sel_found_d = sel_found_d;
         end
      end
   end

   // A handshake releases the grant unless the requester holds it locked
   always_comb begin
`ifdef ARBITER_LOCK_EN
      release_d = bus.gnt_ready & ~bus.lock;
`else
      release_d = bus.gnt_ready;
`endif
   end

   // Arbitration FSM with registered grant outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel_found_d) begin
                  gnt_idx_q   <= sel_idx_d;
                  gnt_valid_q <= 1'b1;
                  state_q     <= GRANT;
               end else begin
                  gnt_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            GRANT: begin
               // Request deassertion is ignored here: grants stay until accepted
               if (release_d) begin
                  ptr_q       <= gnt_idx_q + PTR_STEP;
                  gnt_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  gnt_valid_q <= 1'b1;
                  state_q     <= GRANT;
               end
            end
            default: begin
               gnt_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt_idx   = gnt_idx_q;
   assign bus.gnt_valid = gnt_valid_q;

endmodule
